regfile_arbiter: RTL

Sequencer and arbiter sharing the single-clock register file between the core datapath and the debug module. It owns all register-file control pins (write enable, three addresses, write data) and tracks the register file's one-cycle registered read latency so that read data returns to the requester that issued the read. Core has priority, with an optional starvation guard for debug. It sits directly between the decode/writeback stages, the debug module, and the register file instance.

---
 rtl/regfile_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares one register file between the core datapath and the
// debug module. The core has priority; every cycle exactly one owner (CORE,
// DBG or NONE) drives all register-file control pins. Reads have a one-cycle
// registered latency, so the owner of each granted read is remembered for one
// cycle to route the returning data valid to the right requester.
//
// Optional feature: define REGFILE_ARB_STARVE_GUARD_EN to build the debug
// starvation guard (debug is forced in after STARVE_LIMIT consecutive cycles
// of waiting behind core grants). Without the macro, core priority is strict.
//
// Handshake: a grant (core_gnt / dbg_ready) is combinational in the same cycle
// as the request and the access commits at that rising edge; requesters hold
// their request and payload stable until granted. core_rvalid / dbg_rvalid
// assert exactly one cycle after a granted read and are never stalled.

module regfile_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic [4:0]  core_rs1,
    input  logic [4:0]  core_rs2,
    input  logic        core_we,
    input  logic [4:0]  core_rd,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_rvalid,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ready,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_a1,
    output logic [4:0]  rf_a2,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    owner_t owner;
    owner_t rd_owner;
    logic   force_dbg;
    logic   we_sel;

    // The core consumes RD2 straight from the register file; only RD1 is
    // steered back to debug.
    logic unused_rd2;
    assign unused_rd2 = ^rf_rd2;

`ifdef REGFILE_ARB_STARVE_GUARD_EN
    logic [7:0] starve_cnt;

    // Count consecutive cycles debug waits behind a core grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 8'd0;
        end else if (!dbg_req || dbg_ready) begin
            starve_cnt <= 8'd0;
        end else if (core_gnt) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    assign force_dbg = (starve_cnt == 8'(STARVE_LIMIT));
`else
    // Strict core priority; the limit only matters when the guard is built in.
    logic unused_limit;
    assign unused_limit = ^32'(STARVE_LIMIT);
    assign force_dbg    = 1'b0;
`endif

    // Pick this cycle's owner; nothing is granted while reset is asserted.
    always_comb begin
        owner = OWN_NONE;
        if (!rst) begin
            if (dbg_req && (!core_req || force_dbg)) begin
                owner = OWN_DBG;
            end else if (core_req) begin
                owner = OWN_CORE;
            end
        end
    end

    // The owner drives every register-file pin; writes to x0 are suppressed.
    always_comb begin
        core_gnt  = 1'b0;
        dbg_ready = 1'b0;
        rf_a1     = 5'd0;
        rf_a2     = 5'd0;
        rf_a3     = 5'd0;
        rf_wdata  = 32'd0;
        we_sel    = 1'b0;
        case (owner)
            OWN_CORE: begin
                core_gnt = 1'b1;
                rf_a1    = core_rs1;
                rf_a2    = core_rs2;
                rf_a3    = core_rd;
                rf_wdata = core_wdata;
                we_sel   = core_we;
            end
            OWN_DBG: begin
                dbg_ready = 1'b1;
                rf_a1     = dbg_addr;
                rf_a3     = dbg_addr;
                rf_wdata  = dbg_wdata;
                we_sel    = dbg_we;
            end
            default: begin
            end
        endcase
        rf_we = we_sel && (rf_a3 != 5'd0);
    end

    // Remember who issued the read granted this cycle (debug writes do not read).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner <= OWN_NONE;
        end else begin
            case (owner)
                OWN_CORE: rd_owner <= OWN_CORE;
                OWN_DBG:  rd_owner <= dbg_we ? OWN_NONE : OWN_DBG;
                default:  rd_owner <= OWN_NONE;
            endcase
        end
    end

    // A read pending across a reset is dropped rather than returned.
    assign core_rvalid = !rst && (rd_owner == OWN_CORE);
    assign dbg_rvalid  = !rst && (rd_owner == OWN_DBG);
    assign dbg_rdata   = dbg_rvalid ? rf_rd1 : 32'd0;

endmodule
